// File: rtl/vga_scan_timing_pkg.sv
`default_nettype none
//============================================================================
// vga_scan_timing_pkg - shared 640x480@60 raster constants and helpers
// Revision 1.0 - initial release
//============================================================================
package vga_scan_timing_pkg;

    localparam int c_coord_w  = 11;

    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;
    localparam int c_hs_start = c_h_active + c_h_fp;
    localparam int c_hs_end   = c_hs_start + c_h_sync - 1;

    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;
    localparam int c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;
    localparam int c_vs_start = c_v_active + c_v_fp;
    localparam int c_vs_end   = c_vs_start + c_v_sync - 1;

    localparam int c_frame2_row = 490;
    // Screen bounds shared with the sprite blocks
    localparam int c_ground_row = 400;

    typedef logic [c_coord_w-1:0] coord_t;

    // Position one axis would take on the next clock
    function automatic coord_t axis_next(input coord_t cur, input coord_t last, input logic en);
        if (!en)
            return cur;
        return (cur == last) ? '0 : cur + coord_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_scan_timing_if.sv
`default_nettype none
//============================================================================
// vga_scan_timing_if - raster position/sync bundle between timing and sprites
// Revision 1.0 - initial release
//============================================================================
interface vga_scan_timing_if;
    import vga_scan_timing_pkg::*;

    logic       pix_en;
    coord_t     col;
    coord_t     row;
    logic       hs;
    logic       vs;
    logic       active;
    logic       frame1;
    logic       frame2;
    logic [7:0] frame_cnt;

    modport master (
        input  pix_en,
        output col, row, hs, vs, active, frame1, frame2, frame_cnt
    );

    modport slave (
        output pix_en,
        input  col, row, hs, vs, active, frame1, frame2, frame_cnt
    );

endinterface
`default_nettype wire

// File: rtl/vga_scan_timing_scan_axis_counter.sv
`default_nettype none
//============================================================================
// scan_axis_counter - wrapping 0..MAX axis counter, parks at MAX in reset
// Revision 1.0 - initial release
//============================================================================
module scan_axis_counter
    import vga_scan_timing_pkg::*;
#(
    parameter int MAX = c_h_total - 1
) (
    input  wire logic clk,
    input  wire logic r_n,
    input  wire logic en,
    output coord_t    cnt,
    output logic      wrap
);

    localparam coord_t c_last = coord_t'(MAX);

    coord_t r_cnt;

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n)
            r_cnt <= c_last;
        else
            r_cnt <= axis_next(r_cnt, c_last, en);
    end

    assign cnt  = r_cnt;
    assign wrap = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/vga_scan_timing.sv
`default_nettype none
//============================================================================
// vga_scan_timing - VGA raster walker with sync, active and game strobes
// Revision 1.0 - initial release
//============================================================================
module vga_scan_timing
    import vga_scan_timing_pkg::*;
#(
    parameter int H_ACTIVE   = c_h_active,
    parameter int H_FP       = c_h_fp,
    parameter int H_SYNC     = c_h_sync,
    parameter int H_BP       = c_h_bp,
    parameter int V_ACTIVE   = c_v_active,
    parameter int V_FP       = c_v_fp,
    parameter int V_SYNC     = c_v_sync,
    parameter int V_BP       = c_v_bp,
    parameter int FRAME2_ROW = c_frame2_row,
    parameter bit SYNC_POL   = 1'b0
) (
    input  wire logic          clk,
    input  wire logic          r_n,
    vga_scan_timing_if.master  bus
);

    localparam int     c_h_tot  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int     c_v_tot  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam coord_t c_h_last = coord_t'(c_h_tot - 1);
    localparam coord_t c_v_last = coord_t'(c_v_tot - 1);
    localparam coord_t c_h_act  = coord_t'(H_ACTIVE);
    localparam coord_t c_v_act  = coord_t'(V_ACTIVE);
    localparam coord_t c_hs_lo  = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t c_hs_hi  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t c_vs_lo  = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t c_vs_hi  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam coord_t c_f2_row = coord_t'(FRAME2_ROW);

    logic   w_pix_en;
    logic   w_h_wrap;
    logic   w_v_wrap;
    logic   w_line_start;
    logic   w_frame_end;
    coord_t w_col;
    coord_t w_row;
    coord_t w_col_nxt;
    coord_t w_row_nxt;

    logic       r_hs;
    logic       r_vs;
    logic       r_active;
    logic       r_frame1;
    logic       r_frame2;
    logic       r_started;
    logic [7:0] r_frame_cnt;

    assign w_pix_en = bus.pix_en;

    scan_axis_counter #(.MAX(c_h_tot - 1)) u_h_cnt (
        .clk  (clk),
        .r_n  (r_n),
        .en   (w_pix_en),
        .cnt  (w_col),
        .wrap (w_h_wrap)
    );

    scan_axis_counter #(.MAX(c_v_tot - 1)) u_v_cnt (
        .clk  (clk),
        .r_n  (r_n),
        .en   (w_line_start),
        .cnt  (w_row),
        .wrap (w_v_wrap)
    );

    // Decode from the upcoming position so every output lines up with col/row
    assign w_line_start = w_pix_en & w_h_wrap;
    assign w_frame_end  = w_line_start & w_v_wrap;
    assign w_col_nxt    = axis_next(w_col, c_h_last, w_pix_en);
    assign w_row_nxt    = axis_next(w_row, c_v_last, w_line_start);

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            r_hs        <= ~SYNC_POL;
            r_vs        <= ~SYNC_POL;
            r_active    <= 1'b0;
            r_frame1    <= 1'b0;
            r_frame2    <= 1'b0;
            r_started   <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_hs     <= (w_col_nxt >= c_hs_lo && w_col_nxt <= c_hs_hi) ? SYNC_POL : ~SYNC_POL;
            r_vs     <= (w_row_nxt >= c_vs_lo && w_row_nxt <= c_vs_hi) ? SYNC_POL : ~SYNC_POL;
            r_active <= (w_col_nxt < c_h_act) && (w_row_nxt < c_v_act);
            r_frame1 <= w_line_start && (w_row_nxt == c_v_act);
            r_frame2 <= w_line_start && (w_row_nxt == c_f2_row);
            if (w_pix_en)
                r_started <= 1'b1;
            // The move out of the parked reset position is not a completed frame
            if (w_frame_end && r_started)
                r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign bus.col       = w_col;
    assign bus.row       = w_row;
    assign bus.hs        = r_hs;
    assign bus.vs        = r_vs;
    assign bus.active    = r_active;
    assign bus.frame1    = r_frame1;
    assign bus.frame2    = r_frame2;
    assign bus.frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
